// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction prefetch buffer: fetch FSM states
// and the size of one instruction in bytes.
package ifetch_pkg;

    localparam int IFETCH_INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {address, instruction} entries in fetch order.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push and a pop in the same cycle on a full FIFO are legal: the popped
// head slot is the one the new entry lands in.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; a flush discards everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Instruction prefetch buffer: runs ahead of the core fetching sequential
// words from a one-cycle-latency instruction memory into a small FIFO.
// A redirect (branch_i) restarts fetching immediately at the new address and
// throws away everything fetched for the old stream.
// Optional build macro IFETCH_FALLTHROUGH_EN: a response arriving while the
// FIFO is empty is presented to the core in its arrival cycle instead of
// being registered first.
module ifetch_prefetch_buf
    import ifetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [31:0]           addr_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int CRD_W   = CNT_W + 2;
    localparam int ENTRY_W = DATA_WIDTH + 32;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(IFETCH_INSTR_BYTES);

    ifetch_state_e state;
    ifetch_state_e state_next;

    logic [ADDR_WIDTH-1:0] fetch_ptr;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue;

    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic                  resp_valid;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [31:0]           out_addr;
    logic                  handshake;
    logic                  store_resp;

    logic [CRD_W-1:0]      credit_need;
    logic                  credit_ok;

    logic                  unused_branch_bits;

    // Redirect target is word aligned and truncated to the memory space
    assign branch_target      = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_branch_bits = ^{branch_addr_i[31:ADDR_WIDTH], branch_addr_i[1:0]};

    // A response for the read issued last cycle belongs to the old stream
    // if a redirect happens now, so it is dropped
    assign resp_valid = inflight & ~branch_i;

    assign fifo_wdata = {32'(inflight_addr), mem_rdata_i};

`ifdef IFETCH_FALLTHROUGH_EN
    logic bypass;

    assign bypass = fifo_empty & resp_valid;

    // Present the arriving response directly when nothing older is queued
    always_comb begin
        out_valid = ~fifo_empty | bypass;
        out_data  = fifo_rdata[DATA_WIDTH-1:0];
        out_addr  = fifo_rdata[ENTRY_W-1:DATA_WIDTH];
        if (bypass) begin
            out_data = mem_rdata_i;
            out_addr = 32'(inflight_addr);
        end
    end

    assign store_resp = resp_valid & ~(bypass & ready_i);
`else
    // Every response goes through the FIFO before reaching the core
    always_comb begin
        out_valid = ~fifo_empty;
        out_data  = fifo_rdata[DATA_WIDTH-1:0];
        out_addr  = fifo_rdata[ENTRY_W-1:DATA_WIDTH];
    end

    assign store_resp = resp_valid;
`endif

    // Storage contents are undefined after reset, so outputs are zeroed
    // whenever nothing valid is being presented
    assign valid_o   = out_valid;
    assign rdata_o   = out_valid ? out_data : '0;
    assign addr_o    = out_valid ? out_addr : '0;
    assign handshake = out_valid & ready_i;

    // The credit check keeps the FIFO from ever overflowing, so the full
    // gate below only matters as a guard for the simultaneous push/pop case
    assign fifo_pop  = handshake & ~fifo_empty;
    assign fifo_push = store_resp & (~fifo_full | fifo_pop);

    // Space needed after this cycle if another read is issued now: current
    // entries, plus the response landing now, plus the new read, minus a pop
    assign credit_need = CRD_W'(fifo_count) + CRD_W'(inflight) + CRD_W'(1)
                       - CRD_W'(handshake);
    assign credit_ok   = (credit_need <= CRD_W'(DEPTH));

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (branch_i),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fetch state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and read issue; a redirect always issues and wins
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_addr = fetch_ptr;
        if (branch_i) begin
            issue      = 1'b1;
            issue_addr = branch_target;
            state_next = FETCH;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                FETCH: begin
                    if (credit_ok) begin
                        issue = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (handshake) begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // No reads may escape while reset is held, even on a redirect
    assign mem_en_o   = issue & ~rst;
    assign mem_addr_o = mem_en_o ? issue_addr : '0;

    // Fetch pointer advances one word per read and wraps with the address width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ptr <= '0;
        end else if (mem_en_o) begin
            fetch_ptr <= issue_addr + STEP;
        end
    end

    // Track the single outstanding read and its address for the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight      <= mem_en_o;
            inflight_addr <= issue_addr;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Self-checking bench for ifetch_prefetch_buf with the default parameters.
// Expected delivery addresses are queued when a redirect is driven and
// popped on every core handshake.
module tb_ifetch_prefetch_buf;
    import ifetch_pkg::*;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef IFETCH_FALLTHROUGH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst;
    logic          branch_i;
    logic [31:0]   branch_addr_i;
    logic          ready_i;
    logic          valid_o;
    logic [DW-1:0] rdata_o;
    logic [31:0]   addr_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;

    logic [31:0] exp_q [$];
    int compared;
    int mismatched;
    int delivered;
    int issued;

    ifetch_prefetch_buf #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .rdata_o       (rdata_o),
        .addr_o        (addr_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {14'h2A5, a[17:0]};
    endfunction

    // Instruction memory: data for the strobed address one cycle later
    always @(posedge clk) begin
        if (mem_en_o) begin
            mem_rdata_i <= word_of(32'(mem_addr_o));
        end else begin
            mem_rdata_i <= 32'hDEAD_BEEF;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then score any
    // handshake and queue the expected stream for a redirect
    task automatic applyStimulus(input logic br, input logic [31:0] ba, input logic rdy);
        logic [31:0] a;
        logic [31:0] exp_a;
        @(negedge clk);
        branch_i      = br;
        branch_addr_i = ba;
        ready_i       = rdy;
        #1;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_word", addr_o, 32'hFFFF_FFFF);
            end else begin
                exp_a = exp_q.pop_front();
                checkOutput("sb_addr", addr_o, exp_a);
                checkOutput("sb_rdata", rdata_o, word_of(exp_a));
            end
            delivered++;
        end
        if (br) begin
            exp_q.delete();
            delivered = 0;
            issued    = 0;
            a = ba & 32'h0003_FFFC;
            for (int i = 0; i < 24; i++) begin
                exp_q.push_back(a);
                a = (a + 32'd4) & 32'h0003_FFFF;
            end
        end
        if (mem_en_o) begin
            issued++;
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        delivered     = 0;
        issued        = 0;
        rst           = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        ready_i       = 1'b0;

        // Reset state, including a redirect attempt while reset is held
        @(negedge clk);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_0500;
        #1;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_rdata", rdata_o, 32'd0);
        checkOutput("rst_addr", addr_o, 32'd0);
        @(negedge clk);
        branch_i = 1'b0;
        rst      = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("idle_no_fetch", 32'(mem_en_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("idle_no_valid", 32'(valid_o), 32'd0);

        // Sequential streaming from 0x20000 with the core always ready
        applyStimulus(1'b1, 32'h0002_0000, 1'b1);
        checkOutput("stream_first_addr", 32'(mem_addr_o), 32'h0002_0000);
        checkOutput("stream_branch_valid", 32'(valid_o), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            checkOutput("stream_mem_en", 32'(mem_en_o), 32'd1);
            checkOutput("stream_mem_addr", 32'(mem_addr_o), 32'h0002_0000 + 32'(4 * k));
            if (k == 1) begin
                checkOutput("stream_latency", 32'(valid_o), (LAT == 1) ? 32'd1 : 32'd0);
            end
        end
        checkOutput("stream_delivered", 32'(delivered), 32'(8 - LAT + 1));

        // Back-pressure fills the buffer, then draining resumes fetching
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b0);
        end
        checkOutput("full_issued", 32'(issued), 32'(DEPTH));
        checkOutput("full_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("full_valid", 32'(valid_o), 32'd1);
        checkOutput("full_head_addr", addr_o, 32'h0000_0100);
        checkOutput("full_state", 32'(dut.state), 32'(FULL));
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("full_pop_no_fetch", 32'(mem_en_o), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("resume_mem_en", 32'(mem_en_o), 32'd1);
        checkOutput("resume_mem_addr", 32'(mem_addr_o), 32'h0000_0110);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        checkOutput("resume_delivered", 32'(delivered), 32'd8);

        // Back-to-back redirects: the 0x40 word must never be presented
        applyStimulus(1'b1, 32'h0000_0040, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        checkOutput("rebranch_mem_addr", 32'(mem_addr_o), 32'h0000_0200);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        checkOutput("rebranch_delivered", 32'(delivered), 32'(5 - LAT + 1));

        // Fetch pointer wraps at the top of the address space
        applyStimulus(1'b1, 32'h0003_FFFC, 1'b1);
        checkOutput("wrap_first_addr", 32'(mem_addr_o), 32'h0003_FFFC);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("wrap_next_addr", 32'(mem_addr_o), 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        checkOutput("wrap_delivered", 32'(delivered), 32'(5 - LAT + 1));

        // Unaligned redirect address is word aligned
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        checkOutput("align_mem_addr", 32'(mem_addr_o), 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
        end
        checkOutput("align_delivered", 32'(delivered), 32'(3 - LAT + 1));

        // Reset with three buffered words and one read outstanding
        applyStimulus(1'b1, 32'h0000_0300, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b0);
        end
        @(negedge clk);
        checkOutput("pre_rst_count", 32'(dut.u_fifo.count), 32'd3);
        checkOutput("pre_rst_inflight", 32'(dut.inflight), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(valid_o), 32'd0);
        checkOutput("mid_rst_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("mid_rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("mid_rst_rdata", rdata_o, 32'd0);
        checkOutput("mid_rst_addr", addr_o, 32'd0);
        checkOutput("mid_rst_count", 32'(dut.u_fifo.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            checkOutput("post_rst_mem_en", 32'(mem_en_o), 32'd0);
            checkOutput("post_rst_valid", 32'(valid_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch_buf.md
IFETCH_PREFETCH_BUF -- requirements
Module: ifetch_prefetch_buf

Interface
REQ-001 Parameter ADDR_WIDTH, default 18, SHALL set the instruction-memory byte-address width; the MSB selects the boot region.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2), SHALL set the prefetch FIFO entry count.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 branch_i  input  1  core redirect request; valid only in the cycle it is high.
REQ-007 branch_addr_i  input  32  redirect byte address.
REQ-008 ready_i  input  1  core accepts the word on rdata_o this cycle.
REQ-009 valid_o  output  1  rdata_o/addr_o hold a valid instruction.
REQ-010 rdata_o  output  DATA_WIDTH  instruction word.
REQ-011 addr_o  output  32  byte address of rdata_o.
REQ-012 mem_en_o  output  1  memory read strobe.
REQ-013 mem_addr_o  output  ADDR_WIDTH  memory byte address.
REQ-014 mem_rdata_i  input  DATA_WIDTH  memory read data, valid exactly one cycle after mem_en_o.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH and FULL.
REQ-016 IDLE SHALL issue no reads and SHALL go to FETCH on branch_i.
REQ-017 FETCH SHALL assert mem_en_o whenever fifo_count + inflight + 1 <= DEPTH, after counting a same-cycle pop.
REQ-018 FETCH SHALL go to FULL when that credit check fails; FULL SHALL return to FETCH the cycle after a pop.
REQ-019 Each issued read SHALL advance the fetch pointer by 4 and wrap modulo 2^ADDR_WIDTH.
REQ-020 branch_i SHALL force the fetch pointer to {branch_addr_i[ADDR_WIDTH-1:2],2'b00}; bits 1:0 SHALL be ignored.
REQ-021 branch_i SHALL issue the read in the same cycle, from any state, with no credit check.
REQ-022 branch_i SHALL empty the FIFO and SHALL discard any response for a read issued in the preceding cycle.
REQ-023 A handshake (valid_o & ready_i) in the same cycle as branch_i SHALL count as delivered, and the flush SHALL follow it.
REQ-024 Each response SHALL be pushed with its address; addr_o SHALL equal the fetch address zero-extended to 32 bits.
REQ-025 Responses SHALL be delivered strictly in order; valid_o SHALL be high iff the FIFO is non-empty (see REQ-030).
REQ-026 rdata_o/addr_o SHALL stay stable while valid_o & ~ready_i.
REQ-027 A simultaneous push and pop on a full FIFO SHALL be legal, and no entry SHALL ever be overwritten.
REQ-028 inflight SHALL be 0 or 1 in every cycle.

Reset
REQ-029 While rst is high: state=IDLE; valid_o, mem_en_o, mem_addr_o, rdata_o, addr_o, fifo_count, inflight all 0; an in-flight response SHALL be dropped; rst deasserting mid-fetch SHALL resume only on branch_i.

Configuration
REQ-030 With IFETCH_FALLTHROUGH_EN defined, a response arriving while the FIFO is empty SHALL drive valid_o/rdata_o combinationally in the arrival cycle.
REQ-031 In that case the response SHALL be stored only if ready_i is low.
REQ-032 With IFETCH_FALLTHROUGH_EN undefined, every response SHALL be registered first, giving a 2-cycle branch-to-valid_o latency instead of 1.

Structure
REQ-033 Package ifetch_pkg SHALL hold the FSM state enum ifetch_state_e and the constant IFETCH_INSTR_BYTES=4.
REQ-034 The FIFO SHALL be sub-module ifetch_fifo (DEPTH x (DATA_WIDTH+32)), with push/pop/flush/full/empty/count.

Verification
REQ-035 branch_addr_i=0x20000, ready_i=1 held -> mem_addr_o 0x20000, 0x20004, 0x20008…; valid_o from cycle+1 (fallthrough) or +2 (registered); addr_o follows in order.
REQ-036 ready_i=0 after branch to 0x100 -> exactly DEPTH words 0x100..0x10C buffered, FULL entered, mem_en_o low; ready_i=1 -> 0x100 delivered first, fetching resumes at 0x110.
REQ-037 branch to 0x40 then, on the next cycle, branch to 0x200 -> the word for 0x40 is never presented; first valid addr_o=0x200.
REQ-038 branch_addr_i=0x3FFFC (ADDR_WIDTH=18) -> next mem_addr_o wraps to 0x00000.
REQ-039 branch_addr_i=0x103 -> mem_addr_o=0x100; addr_o=0x100.
REQ-040 rst asserted with 3 buffered words and 1 in flight -> all outputs 0 next edge; after release, no mem_en_o until branch_i.
